acc_adder_arbiter: RTL and testbench
====================================

Name: acc_adder_arbiter

Overview:
- Shares one pipelined adder among NREQ accumulator requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and arbitrates round-robin.
- Issues at most one operation per cycle to the adder and tracks in-flight tags through the adder latency.
- Returns sum and carry to the originating requester through a held response register.
- Sits between the accumulator instances and the single shared adder instance selected by the design configuration.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand and sum width in bits.
- LATENCY, 2, fixed adder latency in cycles from add_valid to add_sum/add_carry (1..8).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- rsp_valid  output  NREQ  per-requester result valid.
- rsp_ready  input  NREQ  per-requester result accept.
- rsp_sum  output  NREQ*WIDTH  per-requester held sum; same packing as req_a.
- rsp_carry  output  NREQ  per-requester held carry-out.
- add_valid  output  1  operation issued to the adder this cycle.
- add_a  output  WIDTH  adder operand A.
- add_b  output  WIDTH  adder operand B.
- add_sum  input  WIDTH  adder sum, valid LATENCY cycles after add_valid.
- add_carry  input  1  adder carry, aligned with add_sum.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs 0.
  - Round-robin pointer = 0.
  - All busy flags, response registers and the tag pipeline cleared.
- Per-requester busy[i] register:
  - Set on issue (req_valid[i] && req_ready[i]).
  - Cleared on response handshake (rsp_valid[i] && rsp_ready[i]).
  - Each requester has at most one operation outstanding.
- Eligibility: eligible[i] = req_valid[i] && !busy[i], using the registered busy value.
  - A response accepted in cycle t makes requester i eligible from t+1, not in t.
- Arbitration (combinational):
  - grant = first eligible index searching upward from the pointer, wrapping modulo NREQ.
  - req_ready[i] = 1 only for the granted index.
  - req_ready never depends on rsp_ready or on add_sum.
- Issue (same cycle as grant):
  - add_valid = 1; add_a/add_b = the granted requester's operands.
  - With no grant: add_valid = 0, add_a = 0, add_b = 0.
- Pointer: on issue, the pointer becomes (grant+1) mod NREQ; otherwise it is unchanged.
- Tag pipeline:
  - LATENCY-deep shift register of {valid, index}, loaded on issue with {1, grant}, else {0, x}.
  - When the output stage is valid with index k:
    - add_sum and add_carry are registered into rsp_sum[k] and rsp_carry[k].
    - rsp_valid[k] is set in the following cycle.
    - Total latency from req handshake edge to rsp_valid high = LATENCY+1 cycles.
- Response hold: rsp_valid[k], rsp_sum[k] and rsp_carry[k] are held stable until rsp_ready[k].
  - rsp_valid[k] clears on the cycle after the handshake; rsp_sum[k] keeps its last value.
- Result slot conflicts cannot occur, because busy[k] blocks reissue until the handshake; no overflow logic is required.
- Throughput: one issue per cycle; full rate when NREQ >= LATENCY+2 with prompt rsp_ready.
- Arithmetic: {add_carry, add_sum} is passed through unmodified; the block performs no addition.
- Simultaneous events:
  - A tag output for k and rsp_ready[k] in the same cycle cannot occur (busy protocol).
  - Issue and response handshakes on different requesters in the same cycle are independent.
- Reset mid-operation:
  - In-flight tags are discarded.
  - Adder outputs arriving after reset deassertion are ignored because the tag pipeline is clear.
- add_valid is never asserted during reset.

Test Plan:
- Single op: LATENCY=2; requester 0 sends a=0x1234, b=0x0101; adder returns 0x1335, carry 0 -> rsp_valid[0] high 3 cycles after the handshake, rsp_sum[0]=0x1335, rsp_carry[0]=0.
- Contention: all 4 req_valid asserted in the same cycle at pointer 0 -> grants 0,1,2,3 on consecutive cycles; add_valid high 4 consecutive cycles.
- Fairness: requesters 1 and 3 continuously valid, rsp_ready always 1, 20 cycles -> grants alternate 1,3,1,3, with no requester starved beyond NREQ-1 cycles.
- Backpressure: requester 2 result with rsp_ready[2]=0 for 10 cycles -> rsp_sum[2] stable, req_ready[2]=0 throughout; rsp_ready[2]=1 -> req_ready[2] may assert 1 cycle later.
- Overflow pass-through: a=0xFFFF, b=0x0001, adder returns 0x0000, carry 1 -> rsp_sum=0x0000, rsp_carry=1.
- Reset mid-op: rst_n low 1 cycle after issue -> all outputs 0 immediately; the stale adder result at LATENCY produces no rsp_valid; the next op completes normally.

Source files
------------

// File: rtl/acc_adder_arbiter.sv
// acc_adder_arbiter
//   Shares one pipelined adder among NREQ accumulator requesters. Operand
//   pairs are accepted over per-requester valid/ready handshakes. A
//   round-robin arbiter grants them, and at most one operation per cycle is
//   issued to the adder. A tag pipeline follows each operation through the
//   adder latency. The result is captured into a per-requester response
//   register, which is held until that requester accepts it. The block does
//   no arithmetic itself: {add_carry, add_sum} passes through unchanged.
//
// Ports
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   req_valid/ready [NREQ]   per-requester operation handshake (ready one-hot)
//   req_a/req_b [NREQ*WIDTH] operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/ready [NREQ]   per-requester result handshake
//   rsp_sum [NREQ*WIDTH]     held sums, same packing as req_a
//   rsp_carry [NREQ]         held carry-outs
//   add_valid/add_a/add_b    issue port to the shared adder
//   add_sum/add_carry        adder result, LATENCY cycles after add_valid
module acc_adder_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [NREQ*WIDTH-1:0]   rsp_sum,
  output logic [NREQ-1:0]         rsp_carry,
  output logic                    add_valid,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_carry
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  busy;
  logic [NREQ-1:0]  eligible;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic             grant_vld;
  logic [NREQ-1:0]  rsp_hs;
  logic [NREQ-1:0]  deliver;

  // Tag pipeline: stage p0 is loaded on issue. Stage LATENCY-1 lines up
  // with add_sum/add_carry.
  logic             tag_vld_p [LATENCY];
  logic [IDX_W-1:0] tag_idx_p [LATENCY];

  // Eligibility is masked while reset is asserted, so no grant and no
  // add_valid can appear during reset, even with req_valid held high.
  always_comb begin
    eligible = rst_n ? (req_valid & ~busy) : '0;
  end

  // Round-robin search upward from ptr, wrapping modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int o = 0; o < NREQ; o++) begin
      if (!grant_vld && eligible[(int'(ptr) + o) % NREQ]) begin
        grant_vld = 1'b1;
        grant     = IDX_W'((int'(ptr) + o) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (grant_vld) begin
      req_ready[grant] = 1'b1;
      add_a = req_a[int'(grant)*WIDTH +: WIDTH];
      add_b = req_b[int'(grant)*WIDTH +: WIDTH];
    end
    add_valid = grant_vld;
  end

  always_comb begin
    rsp_hs  = rsp_valid & rsp_ready;
    deliver = '0;
    if (tag_vld_p[LATENCY-1]) deliver[tag_idx_p[LATENCY-1]] = 1'b1;
  end

  // ---- issue stage -> tag pipeline / arbiter state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      busy <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        tag_vld_p[s] <= 1'b0;
        tag_idx_p[s] <= '0;
      end
    end else begin
      if (grant_vld)
        ptr <= (grant == IDX_W'(NREQ-1)) ? '0 : grant + IDX_W'(1);
      // A response handshake frees the slot. The new busy value takes
      // effect from the next cycle, because eligibility uses the register.
      busy <= (busy & ~rsp_hs) | req_ready;
      tag_vld_p[0] <= grant_vld;
      tag_idx_p[0] <= grant;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_idx_p[s] <= tag_idx_p[s-1];
      end
    end
  end

  // ---- adder output stage -> held response registers ----
  // busy[k] prevents a new tag for k from arriving while rsp_valid[k] is
  // pending, so capture and handshake never collide on one slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_carry <= '0;
    end else begin
      rsp_valid <= (rsp_valid & ~rsp_hs) | deliver;
      if (tag_vld_p[LATENCY-1]) begin
        rsp_sum[int'(tag_idx_p[LATENCY-1])*WIDTH +: WIDTH] <= add_sum;
        rsp_carry[tag_idx_p[LATENCY-1]]                     <= add_carry;
      end
    end
  end

endmodule

// File: tb/tb_acc_adder_arbiter.sv
// Testbench for acc_adder_arbiter. It drives directed and random traffic,
// models the shared adder, and compares every cycle against a transaction
// model built from queues.
module tb_acc_adder_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready, rsp_carry;
  logic [N*W-1:0]   req_a, req_b, rsp_sum;
  logic             add_valid, add_carry;
  logic [W-1:0]     add_a, add_b, add_sum;

  int checks   = 0;
  int failures = 0;

  acc_adder_arbiter #(.NREQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_carry(add_carry)
  );

  always #5 clk = ~clk;

  // Shared adder with fixed latency L. Cycles without a valid operation
  // feed random data into the pipe, so stale or idle slots carry garbage.
  logic [W:0] apipe [L];
  always @(posedge clk) begin
    apipe[0] <= add_valid ? ({1'b0, add_a} + {1'b0, add_b}) : (W+1)'($urandom);
    for (int s = 1; s < L; s++) apipe[s] <= apipe[s-1];
  end
  assign add_sum   = apipe[L-1][W-1:0];
  assign add_carry = apipe[L-1][W];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference model.
  typedef struct {
    int         due;
    int         idx;
    logic [W:0] res;
  } op_t;

  op_t        infl[$];
  bit         mbusy [N];
  bit         mv    [N];
  logic [W-1:0] ms  [N];
  bit         mc    [N];
  int         mptr    = 0;
  int         m_grant = -1;
  int         cyc     = 0;
  int         mj;

  // Compare all outputs mid-cycle, after the inputs have settled.
  always @(negedge clk) begin
    logic [N-1:0]   e_ready, e_rv, e_rc;
    logic [N*W-1:0] e_rs;
    logic [W-1:0]   e_a, e_b;
    m_grant = -1;
    if (rst_n) begin
      for (int o = 0; o < N; o++) begin
        mj = (mptr + o) % N;
        if (m_grant < 0 && req_valid[mj] && !mbusy[mj]) m_grant = mj;
      end
    end
    e_ready = '0;
    e_a     = '0;
    e_b     = '0;
    if (m_grant >= 0) begin
      e_ready[m_grant] = 1'b1;
      e_a = req_a[m_grant*W +: W];
      e_b = req_b[m_grant*W +: W];
    end
    for (int i = 0; i < N; i++) begin
      e_rv[i]          = rst_n ? mv[i] : 1'b0;
      e_rc[i]          = rst_n ? mc[i] : 1'b0;
      e_rs[i*W +: W]   = rst_n ? ms[i] : '0;
    end
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("add_valid", 64'(add_valid), 64'(m_grant >= 0));
    chk("add_a",     64'(add_a),     64'(e_a));
    chk("add_b",     64'(add_b),     64'(e_b));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_sum",   64'(rsp_sum),   64'(e_rs));
    chk("rsp_carry", 64'(rsp_carry), 64'(e_rc));
  end

  // Advance the model at each clock edge, using the inputs seen this cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      infl.delete();
      mptr = 0;
      for (int i = 0; i < N; i++) begin
        mbusy[i] = 0; mv[i] = 0; ms[i] = '0; mc[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (mv[i] && rsp_ready[i]) begin
          mv[i]    = 0;
          mbusy[i] = 0;
        end
      if (m_grant >= 0) begin
        mbusy[m_grant] = 1;
        mptr = (m_grant + 1) % N;
        infl.push_back('{due: cyc + L + 1, idx: m_grant,
                         res: {1'b0, req_a[m_grant*W +: W]} + {1'b0, req_b[m_grant*W +: W]}});
      end
    end
    cyc++;
    while (infl.size() > 0 && infl[0].due == cyc) begin
      mv[infl[0].idx] = 1;
      ms[infl[0].idx] = infl[0].res[W-1:0];
      mc[infl[0].idx] = infl[0].res[W];
      void'(infl.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int prev_g;

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outputs", {add_valid, req_ready, rsp_valid, rsp_carry}, 64'd0);
    step();
    rst_n = 1'b1;

    // Single operation on requester 0.
    req_valid = 4'b0001; req_a[15:0] = 16'h1234; req_b[15:0] = 16'h0101;
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'h1);
    chk("single_add_a", 64'(add_a), 64'h1234);
    step(); req_valid = '0;
    @(negedge clk); chk("single_rv_c1", 64'(rsp_valid[0]), 64'h0);
    step();
    @(negedge clk); chk("single_rv_c2", 64'(rsp_valid[0]), 64'h0);
    step(); rsp_ready = 4'b0001;
    @(negedge clk);
    chk("single_rv_c3", 64'(rsp_valid[0]), 64'h1);
    chk("single_sum",   64'(rsp_sum[15:0]), 64'h1335);
    chk("single_carry", 64'(rsp_carry[0]), 64'h0);
    step(); rsp_ready = '0;
    @(negedge clk);
    chk("single_rv_clr",  64'(rsp_valid[0]), 64'h0);
    chk("single_sum_kept", 64'(rsp_sum[15:0]), 64'h1335);

    // Overflow pass-through and backpressure on requester 2.
    step();
    rsp_ready = 4'b1011; req_valid = 4'b0100;
    req_a[47:32] = 16'hFFFF; req_b[47:32] = 16'h0001;
    @(negedge clk); chk("ovf_ready", 64'(req_ready), 64'h4);
    repeat (3) step();
    @(negedge clk);
    chk("ovf_rv",    64'(rsp_valid[2]), 64'h1);
    chk("ovf_sum",   64'(rsp_sum[47:32]), 64'h0000);
    chk("ovf_carry", 64'(rsp_carry[2]), 64'h1);
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      chk("bp_ready2", 64'(req_ready[2]), 64'h0);
      chk("bp_sum2",   64'(rsp_sum[47:32]), 64'h0000);
      chk("bp_rv2",    64'(rsp_valid[2]), 64'h1);
    end
    step(); rsp_ready = 4'b1111;
    @(negedge clk); chk("bp_release_same", 64'(req_ready[2]), 64'h0);
    step();
    @(negedge clk); chk("bp_release_next", 64'(req_ready[2]), 64'h1);
    step(); req_valid = '0;
    repeat (6) step();

    // Contention from pointer 0.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("cont_ready", 64'(req_ready), 64'(1 << k));
      chk("cont_add_valid", 64'(add_valid), 64'h1);
      step();
    end
    req_valid = '0;
    repeat (6) step();

    // Reset one cycle after issue: the stale adder result must be dropped.
    req_valid = 4'b0010; req_a[31:16] = 16'h00AA; req_b[31:16] = 16'h0055;
    @(negedge clk); chk("rst_issue", 64'(req_ready), 64'h2);
    step(); req_valid = '0; rst_n = 1'b0;
    @(negedge clk); chk("rst_zero", {add_valid, req_ready, rsp_valid, rsp_sum}, 64'd0);
    step(); rst_n = 1'b1;
    @(negedge clk); chk("rst_stale_c2", 64'(rsp_valid), 64'h0);
    step();
    @(negedge clk); chk("rst_stale_c3", 64'(rsp_valid), 64'h0);
    step(); rsp_ready = '0; req_valid = 4'b0010;
    step(); req_valid = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_next_rv",  64'(rsp_valid), 64'h2);
    chk("rst_next_sum", 64'(rsp_sum[31:16]), 64'h00FF);
    step(); rsp_ready = 4'b1111;
    repeat (3) step();

    // Fairness: requesters 1 and 3 compete, and each grant alternates.
    prev_g = -1;
    req_valid = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (add_valid) begin
        chk("fair_onehot", 64'(req_ready == 4'b0010 || req_ready == 4'b1000), 64'h1);
        if (prev_g >= 0) chk("fair_alternate", 64'(req_ready != 4'(prev_g)), 64'h1);
        prev_g = int'(req_ready);
      end
      step();
    end
    req_valid = '0;
    repeat (6) step();

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      req_valid = 4'($urandom);
      rsp_ready = 4'($urandom) | 4'($urandom);
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end
    req_valid = '0; rsp_ready = 4'b1111;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
